// File: rtl/seq_mul_add.sv
// seq_mul_add: iterative shift-add y = q*b + r, one multiplier bit per clock, start/busy/done handshake.
// Optional MULADD_CHECK_EN: registers err = (r >= b) at start acceptance; otherwise err is tied low.
module seq_mul_add #(
    parameter int WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   r,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y,
    output logic               err
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [WIDTH-1:0] qreg_reg;
    logic [AW-1:0]    mb_reg;
    logic [AW-1:0]    acc_reg;
    logic [AW-1:0]    acc_sum;
    logic [CW-1:0]    count_reg;
    logic [AW-1:0]    y_reg;
    logic             last_step;

    assign last_step = (count_reg == CW'(WIDTH - 1));
    assign acc_sum   = acc_reg + (qreg_reg[0] ? mb_reg : '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the state register only, never start directly
    always_comb begin
        busy = (state_reg == RUN) || (state_reg == DONE);
        done = (state_reg == DONE);
    end

    // Shift-add datapath; y only updates on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qreg_reg  <= '0;
            mb_reg    <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            y_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        qreg_reg  <= q;
                        mb_reg    <= {{WIDTH{1'b0}}, b};
                        acc_reg   <= {{WIDTH{1'b0}}, r};
                        count_reg <= '0;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_sum;
                    qreg_reg  <= qreg_reg >> 1;
                    mb_reg    <= mb_reg << 1;
                    count_reg <= count_reg + CW'(1);
                    if (last_step) begin
                        y_reg <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y = y_reg;

`ifdef MULADD_CHECK_EN
    logic err_reg;

    // An illegal remainder for its divisor (includes b == 0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            err_reg <= (r >= b);
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add: scoreboard queue of expected {y, err} popped on each done pulse.
module tb_seq_mul_add;

    localparam int WIDTH = 7;
    localparam int AW    = 2 * WIDTH;

    typedef struct {
        logic [AW-1:0] y;
        logic          err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic [AW-1:0]    y;
    logic             err;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    seq_mul_add #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .q     (q),
        .b     (b),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] qi, input logic [WIDTH-1:0] bi,
                                   input logic [WIDTH-1:0] ri);
        exp_t e;
        e.y = AW'(qi) * AW'(bi) + AW'(ri);
`ifdef MULADD_CHECK_EN
        e.err = (ri >= bi);
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    // Drive a one-cycle start at a negedge and queue its expected result
    task automatic drive_start(input logic [WIDTH-1:0] qi, input logic [WIDTH-1:0] bi,
                               input logic [WIDTH-1:0] ri, input bit push);
        @(negedge clk);
        start = 1'b1;
        q = qi;
        b = bi;
        r = ri;
        if (push) sb_q.push_back(model(qi, bi, ri));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done (bounded), pop scoreboard and compare; returns negedges since start edge
    task automatic wait_done(input string tag, output int lat);
        exp_t e;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'(done), 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_y"}, 32'(y), 32'(e.y));
            chk({tag, "_err"}, 32'(err), 32'(e.err));
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] qi,
                          input logic [WIDTH-1:0] bi, input logic [WIDTH-1:0] ri);
        int lat;
        drive_start(qi, bi, ri, 1'b1);
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        wait_done(tag, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int n_done;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        q = '0;
        b = '0;
        r = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        run_op("basic", 7'd5, 7'd9, 7'd4);
        chk("basic_const_y", 32'(y), 32'h31);
        run_op("max", 7'd127, 7'd127, 7'd126);
        chk("max_const_y", 32'(y), 32'h3F7F);
        run_op("q_zero", 7'd0, 7'd100, 7'd3);
        run_op("b_zero", 7'd100, 7'd0, 7'd0);
        run_op("chk_eq", 7'd1, 7'd5, 7'd5);
        run_op("chk_lt", 7'd1, 7'd5, 7'd4);
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rand%0d", i), 7'($urandom), 7'($urandom), 7'($urandom));
        end

        // Start during busy must be ignored, not queued
        drive_start(7'd3, 7'd4, 7'd1, 1'b1);
        @(negedge clk);
        start = 1'b1;
        q = 7'd7;
        b = 7'd7;
        r = 7'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign", lat);
        n_done = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("busy_ign_done_count", 32'(n_done), 32'd1);
        chk("busy_ign_y_held", 32'(y), 32'd13);
        run_op("after_hold", 7'd5, 7'd9, 7'd4);

        // Asynchronous reset during RUN step 3
        drive_start(7'd127, 7'd127, 7'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_y", 32'(y), 32'd0);
        #1 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("arst_no_done", 32'(n_done), 32'd0);
        run_op("post_rst", 7'd2, 7'd3, 7'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
